mem_request_arbiter: RTL and testbench
======================================

Name: mem_request_arbiter

Overview:
- Arbitrates NUM_CH requestors (instruction fetch, data load/store, future DMA/debug) onto one single-ported RAM port with fixed access latency.
- Sits between the core datapath and the RAM wrapper; replaces the fixed two-client instruction/data split with a parametrised multi-channel handshake unit.
- Each request is held by its requestor until a one-cycle ready pulse returns on that channel.

Parameters:
NUM_CH, 2, number of requesting channels (2..8); channel 0 = instruction fetch
ADDR_W, 32, address width
DATA_W, 32, data width
RAM_LAT, 1, RAM cycles from issue to valid read data / write commit (1..15)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
req  in  NUM_CH  per-channel request, held high until ready
wen  in  NUM_CH  per-channel write enable (1 = store, 0 = load), valid with req
addr  in  NUM_CH*ADDR_W  packed per-channel address, channel i at [i*ADDR_W +: ADDR_W]
wdata  in  NUM_CH*DATA_W  packed per-channel store data
ready  out  NUM_CH  one-cycle completion pulse per channel
rdata  out  DATA_W  load data, valid in the cycle ready is high
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM store data
ram_ren  out  1  RAM read strobe
ram_wen  out  1  RAM write strobe
ram_rdata  in  DATA_W  RAM read data, valid RAM_LAT cycles after issue
busy  out  1  high while a transaction is in flight
grant  out  $clog2(NUM_CH)  index of channel currently served

Behaviour:
- Reset (rst high at clock edge): state IDLE; ready=0, rdata=0, ram_addr=0, ram_wdata=0, ram_ren=0, ram_wen=0, busy=0, grant=0; round-robin pointer=0; latency counter=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req bit is set, select a winner (see arbitration). Latch addr, wdata and wen of the winner. Drive ram_addr/ram_wdata. Assert ram_ren (load) or ram_wen (store) for exactly one cycle. Load counter with RAM_LAT-1, set busy=1, grant=winner, and go to ACCESS. With no req, stay in IDLE.
- ACCESS: ram_ren/ram_wen are 0. Decrement counter; when counter==0, capture ram_rdata into rdata (loads only; stores leave rdata unchanged) and go to RESP.
- RESP: ready[grant]=1 for this cycle only. busy=0. Advance RR pointer to grant+1, wrapping mod NUM_CH. Return to IDLE.
- Latency: req seen in IDLE at edge N -> ready pulse at edge N+RAM_LAT+1. Minimum spacing between back-to-back grants is RAM_LAT+2 cycles.
- Latched request fields are used for the whole transaction. Requestor changes to addr/wdata/wen after the grant have no effect.
- If req drops mid-transaction, the transaction still completes and ready still pulses.
- A channel re-asserting req in the cycle after its ready counts as a new request.
- Simultaneous requests: only one grant per IDLE cycle. Losers stay pending with no ready pulse.
- Only one ready bit can be high in any cycle. ready is never high while busy=1.
- rst asserted mid-transaction: abort immediately to reset values. No ready pulse for the aborted transaction, and no further RAM strobe.
- Out-of-range channel index cannot occur. grant is always < NUM_CH.

Optional Feature:
- Macro RR_ARB_EN.
- Defined: round-robin arbitration. Search starts at the RR pointer and takes the first set req bit at or after it, wrapping.
- Undefined: fixed priority, lowest index wins (instruction fetch first). The RR pointer is not implemented, and grant order depends only on the req vector.

Test Plan:
- Reset then single load: NUM_CH=2, RAM_LAT=1, req[1]=1, wen=0, addr1=0x40, ram_rdata=0xDEADBEEF -> ram_ren pulse with ram_addr=0x40; ready=2'b10 two cycles later with rdata=0xDEADBEEF; busy high only during ACCESS.
- Store: req[0]=1, wen[0]=1, addr0=0x10, wdata0=0x1234 -> one-cycle ram_wen with ram_addr=0x10, ram_wdata=0x1234; ready[0] pulses; rdata unchanged.
- Contention, RR_ARB_EN defined, NUM_CH=4, req=4'b1111 held -> grants in order 0,1,2,3,0; each ready separated by RAM_LAT+2 cycles.
- Contention, RR_ARB_EN undefined, req=4'b0110 held -> channel 1 wins every time; channel 2 never served while req[1] stays high.
- Latency: RAM_LAT=3, single load -> ready exactly 4 cycles after the req-sampling edge; addr changed after grant does not alter ram_addr.
- Mid-transaction reset: rst=1 during ACCESS -> all outputs 0 next cycle, no ready pulse; the next request after rst deasserts is served normally.

Source files
------------

// File: rtl/mem_request_arbiter_if.sv
// ============================================================================
// Module      : mem_request_arbiter_if
// Description : Requestor-side and RAM-side signal bundle of the memory
//               request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_request_arbiter_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int c_GW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        wen;
    logic [NUM_CH*ADDR_W-1:0] addr;
    logic [NUM_CH*DATA_W-1:0] wdata;
    logic [NUM_CH-1:0]        ready;
    logic [DATA_W-1:0]        rdata;
    logic [ADDR_W-1:0]        ram_addr;
    logic [DATA_W-1:0]        ram_wdata;
    logic                     ram_ren;
    logic                     ram_wen;
    logic [DATA_W-1:0]        ram_rdata;
    logic                     busy;
    logic [c_GW-1:0]          grant;

    // Arbiter side
    modport slave (
        input  req, wen, addr, wdata, ram_rdata,
        output ready, rdata, ram_addr, ram_wdata, ram_ren, ram_wen, busy, grant
    );

    // Requestor / RAM model side
    modport master (
        output req, wen, addr, wdata, ram_rdata,
        input  ready, rdata, ram_addr, ram_wdata, ram_ren, ram_wen, busy, grant
    );
endinterface

`default_nettype wire

// File: rtl/mem_request_arbiter.sv
// ============================================================================
// Module      : mem_request_arbiter
// Description : Multi-channel request arbiter onto one fixed-latency RAM port.
//               Define RR_ARB_EN for round-robin, otherwise fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_request_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    mem_request_arbiter_if.slave  bus
);
    localparam int         c_GW     = $clog2(NUM_CH);
    localparam logic [3:0] c_LAT_M1 = 4'(RAM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_cnt;
    logic                r_is_wr;
    logic [NUM_CH-1:0]   r_ready;
    logic [DATA_W-1:0]   r_rdata;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_wdata;
    logic                r_ram_ren;
    logic                r_ram_wen;
    logic                r_busy;
    logic [c_GW-1:0]     r_grant;

    logic                w_any;
    logic [c_GW-1:0]     w_winner;

`ifdef RR_ARB_EN
    logic [c_GW-1:0]     r_rr_ptr;
    int                  w_idx;

    // Descending scan so the lowest offset from the pointer is the final winner
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_CH) begin
                w_idx = w_idx - NUM_CH;
            end
            if (bus.req[w_idx]) begin
                w_any    = 1'b1;
                w_winner = c_GW'(w_idx);
            end
        end
    end
`else
    always_comb begin
        w_any    = 1'b0;
        w_winner = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                w_any    = 1'b1;
                w_winner = c_GW'(k);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_ready     <= '0;
            r_rdata     <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_ren   <= 1'b0;
            r_ram_wen   <= 1'b0;
            r_busy      <= 1'b0;
            r_grant     <= '0;
`ifdef RR_ARB_EN
            r_rr_ptr    <= '0;
`endif
        end else begin
            r_ready   <= '0;
            r_ram_ren <= 1'b0;
            r_ram_wen <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_ram_addr  <= bus.addr[int'(w_winner)*ADDR_W +: ADDR_W];
                        r_ram_wdata <= bus.wdata[int'(w_winner)*DATA_W +: DATA_W];
                        r_is_wr     <= bus.wen[w_winner];
                        r_ram_ren   <= ~bus.wen[w_winner];
                        r_ram_wen   <= bus.wen[w_winner];
                        r_cnt       <= c_LAT_M1;
                        r_busy      <= 1'b1;
                        r_grant     <= w_winner;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Ready is registered here so it is visible during RESP
                    if (r_cnt == 4'd0) begin
                        if (!r_is_wr) begin
                            r_rdata <= bus.ram_rdata;
                        end
                        r_ready[r_grant] <= 1'b1;
                        r_busy           <= 1'b0;
                        r_state          <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
`ifdef RR_ARB_EN
                    r_rr_ptr <= (r_grant == c_GW'(NUM_CH - 1)) ? '0 : r_grant + 1'b1;
`endif
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready     = r_ready;
    assign bus.rdata     = r_rdata;
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_wdata = r_ram_wdata;
    assign bus.ram_ren   = r_ram_ren;
    assign bus.ram_wen   = r_ram_wen;
    assign bus.busy      = r_busy;
    assign bus.grant     = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_mem_request_arbiter.sv
// ============================================================================
// Module      : tb_mem_request_arbiter
// Description : Directed bench: 4-channel/latency-1 and 2-channel/latency-3
//               arbiters, vector table plus contention and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_request_arbiter;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mem_request_arbiter_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32)) bus_a ();
    mem_request_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) bus_b ();

    mem_request_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .RAM_LAT(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    mem_request_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RAM_LAT(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ch;
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] rd;
        logic [31:0] erd;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called just after a negedge with the arbiter idle
    task automatic do_txn(input vec_t v);
        logic [3:0] e_rdy;
        e_rdy = 4'b0001 << v.ch;
        bus_a.req               = '0;
        bus_a.req[v.ch]         = 1'b1;
        bus_a.wen               = '0;
        bus_a.wen[v.ch]         = v.w;
        bus_a.addr[v.ch*32 +: 32]  = v.a;
        bus_a.wdata[v.ch*32 +: 32] = v.d;
        bus_a.ram_rdata         = 32'hBAD0_0BAD;
        @(negedge clk);
        check("issue ram_ren",   bus_a.ram_ren, !v.w);
        check("issue ram_wen",   bus_a.ram_wen, v.w);
        check("issue ram_addr",  bus_a.ram_addr, v.a);
        check("issue ram_wdata", bus_a.ram_wdata, v.d);
        check("issue busy",      bus_a.busy, 1);
        check("issue grant",     bus_a.grant, v.ch);
        check("issue ready",     bus_a.ready, 0);
        bus_a.addr[v.ch*32 +: 32] = ~v.a;
        bus_a.wen[v.ch]           = ~v.w;
        bus_a.ram_rdata           = v.rd;
        @(negedge clk);
        check("resp ready",    bus_a.ready, e_rdy);
        check("resp busy",     bus_a.busy, 0);
        check("resp rdata",    bus_a.rdata, v.erd);
        check("resp strobes",  {bus_a.ram_ren, bus_a.ram_wen}, 0);
        check("resp ram_addr", bus_a.ram_addr, v.a);
        bus_a.req = '0;
        @(negedge clk);
        check("post ready", bus_a.ready, 0);
    endtask

    task automatic contend(input logic [3:0] pat, input int exp_g[5]);
        int seen;
        int last;
        int cyc;
        int idx;
        bit overlap;
        seen    = 0;
        last    = 0;
        cyc     = 0;
        overlap = 1'b0;
        bus_a.wen = '0;
        bus_a.req = pat;
        while (seen < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus_a.ready != 0 && bus_a.busy) overlap = 1'b1;
            if (bus_a.ready != 0) begin
                idx = 0;
                for (int i = 0; i < 4; i++) if (bus_a.ready[i]) idx = i;
                check("contend onehot", $onehot(bus_a.ready), 1);
                check("contend order",  idx, exp_g[seen]);
                if (seen > 0) check("contend spacing", cyc - last, 3);
                last = cyc;
                seen++;
            end
        end
        bus_a.req = '0;
        check("contend count", seen, 5);
        check("contend ready-while-busy", overlap, 0);
        @(negedge clk);
        @(negedge clk);
        check("contend drained", bus_a.busy, 0);
    endtask

    vec_t vecs[6];
    int   e_all[5];
    int   e_mid[5];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{ch: 1, w: 1'b0, a: 32'h0000_0040, d: 32'h1111_1111, rd: 32'hDEAD_BEEF, erd: 32'hDEAD_BEEF};
        vecs[1] = '{ch: 0, w: 1'b1, a: 32'h0000_0010, d: 32'h0000_1234, rd: 32'h5555_5555, erd: 32'hDEAD_BEEF};
        vecs[2] = '{ch: 3, w: 1'b0, a: 32'h0000_03FC, d: 32'h2222_2222, rd: 32'hA5A5_A5A5, erd: 32'hA5A5_A5A5};
        vecs[3] = '{ch: 2, w: 1'b1, a: 32'hFFFF_FFFC, d: 32'hFFFF_FFFF, rd: 32'h0000_0000, erd: 32'hA5A5_A5A5};
        vecs[4] = '{ch: 2, w: 1'b0, a: 32'h0000_0000, d: 32'h3333_3333, rd: 32'h0000_0000, erd: 32'h0000_0000};
        vecs[5] = '{ch: 0, w: 1'b0, a: 32'h0000_0100, d: 32'h4444_4444, rd: 32'h0BAD_F00D, erd: 32'h0BAD_F00D};
`ifdef RR_ARB_EN
        e_all = '{0, 1, 2, 3, 0};
        e_mid = '{1, 2, 1, 2, 1};
`else
        e_all = '{0, 0, 0, 0, 0};
        e_mid = '{1, 1, 1, 1, 1};
`endif
        bus_a.req = '0; bus_a.wen = '0; bus_a.ram_rdata = '0;
        bus_a.addr  = {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000};
        bus_a.wdata = {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000};
        bus_b.req = '0; bus_b.wen = '0; bus_b.ram_rdata = '0;
        bus_b.addr  = {32'hE100_0001, 32'hE100_0000};
        bus_b.wdata = {32'hD100_0001, 32'hD100_0000};

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst ready",     bus_a.ready, 0);
        check("rst rdata",     bus_a.rdata, 0);
        check("rst ram_addr",  bus_a.ram_addr, 0);
        check("rst ram_wdata", bus_a.ram_wdata, 0);
        check("rst strobes",   {bus_a.ram_ren, bus_a.ram_wen}, 0);
        check("rst busy",      bus_a.busy, 0);
        check("rst grant",     bus_a.grant, 0);
        check("rst b busy",    bus_b.busy, 0);
        check("rst b ready",   bus_b.ready, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        contend(4'b1111, e_all);
        contend(4'b0110, e_mid);

        // Reset while a load on channel 2 is in flight
        bus_a.req = 4'b0100; bus_a.wen = '0;
        bus_a.addr[2*32 +: 32] = 32'h0000_0200;
        @(negedge clk);
        check("abort busy before", bus_a.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort ready",    bus_a.ready, 0);
        check("abort busy",     bus_a.busy, 0);
        check("abort strobes",  {bus_a.ram_ren, bus_a.ram_wen}, 0);
        check("abort rdata",    bus_a.rdata, 0);
        check("abort ram_addr", bus_a.ram_addr, 0);
        check("abort grant",    bus_a.grant, 0);
        @(negedge clk);
        check("abort no pulse", bus_a.ready, 0);
        rst = 1'b0;
        do_txn('{ch: 2, w: 1'b0, a: 32'h0000_0200, d: 32'h0, rd: 32'h7777_1234, erd: 32'h7777_1234});

        // Latency-3 instance: load on channel 1
        bus_b.req = 2'b10; bus_b.wen = '0;
        bus_b.addr[32 +: 32] = 32'h0000_0080;
        bus_b.ram_rdata = 32'hBAD0_0BAD;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("lat3 ram_ren",  bus_b.ram_ren, 1);
                check("lat3 ram_addr", bus_b.ram_addr, 32'h80);
                bus_b.addr[32 +: 32] = 32'h0000_1234;
            end
            if (c == 2) begin
                check("lat3 addr held",  bus_b.ram_addr, 32'h80);
                check("lat3 strobe one", bus_b.ram_ren, 0);
            end
            if (c < 4) begin
                check("lat3 ready early", bus_b.ready, 0);
                check("lat3 busy",        bus_b.busy, 1);
            end
            if (c == 3) bus_b.ram_rdata = 32'hCAFE_F00D;
            if (c == 4) begin
                check("lat3 ready", bus_b.ready, 2'b10);
                check("lat3 rdata", bus_b.rdata, 32'hCAFE_F00D);
                check("lat3 idle",  bus_b.busy, 0);
                bus_b.req = '0;
            end
        end
        @(negedge clk);
        check("lat3 ready once", bus_b.ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
